// File: rtl/exe_mul_arbiter.sv
// exe_mul_arbiter: two issue requesters share one pipelined signed 33x33
// multiplier. The block does round-robin granting, RISC-V M-extension operand
// extension and tag tracking through the multiplier latency, and it routes
// each result back to the requester that issued it.
// Optional feature: define EXE_MUL_ARB_SCOREBOARD_EN to get per-requester
// pending-rd busy masks with a WAW hold. Without it, busy0/busy1 read 0.
module exe_mul_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [4:0]  req0_rd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [4:0]  req1_rd,
  output logic        mul_valid,
  output logic [32:0] mul_src_a,
  output logic [32:0] mul_src_b,
  input  logic [65:0] mul_result,
  output logic        rsp0_valid,
  output logic [4:0]  rsp0_rd,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  output logic [4:0]  rsp1_rd,
  output logic [31:0] rsp1_result,
  output logic [31:0] busy0,
  output logic [31:0] busy1
);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       id;
    logic       lower;
    logic [4:0] rd;
  } tag_t;

  logic             hold0, hold1;
  logic             elig0, elig1, gnt0, gnt1, hs;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       sel_op;
  logic [31:0]      sel_rs1, sel_rs2;
  logic [4:0]       sel_rd;
  logic [32:0]      src_a_d, src_b_d, src_a_q, src_b_q;
  logic             mul_valid_q;
  tag_t             new_tag, exit_tag;
  tag_t [LATENCY:0] tag_q;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [4:0]       rsp0_rd_q, rsp1_rd_q;
  logic [31:0]      rsp0_result_q, rsp1_result_q;
  logic [31:0]      exit_word;
  logic             unused_mul_hi;

  // The tag leaving the last stage lines up with mul_result.
  assign exit_tag      = tag_q[LATENCY];
  assign exit_word     = exit_tag.lower ? mul_result[31:0] : mul_result[63:32];
  assign unused_mul_hi = ^mul_result[65:64];

`ifdef EXE_MUL_ARB_SCOREBOARD_EN
  logic [31:0] busy0_q, busy0_d, busy1_q, busy1_d;

  // WAW hold: a request waits while its rd is still in flight
  assign hold0 = busy0_q[req0_rd];
  assign hold1 = busy1_q[req1_rd];

  // Clear a bit when its response is registered; set it on the handshake (x0 is never tracked)
  always_comb begin
    busy0_d = busy0_q;
    busy1_d = busy1_q;
    if (exit_tag.valid) begin
      if (exit_tag.id) busy1_d[exit_tag.rd] = 1'b0;
      else             busy0_d[exit_tag.rd] = 1'b0;
    end
    if (gnt0 && (req0_rd != 5'd0)) busy0_d[req0_rd] = 1'b1;
    if (gnt1 && (req1_rd != 5'd0)) busy1_d[req1_rd] = 1'b1;
  end

  // Busy mask registers, cleared by reset and by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy0_q <= '0;
      busy1_q <= '0;
    end else if (flush) begin
      busy0_q <= '0;
      busy1_q <= '0;
    end else begin
      busy0_q <= busy0_d;
      busy1_q <= busy1_d;
    end
  end

  assign busy0 = busy0_q;
  assign busy1 = busy1_q;
`else
  assign hold0 = 1'b0;
  assign hold1 = 1'b0;
  assign busy0 = '0;
  assign busy1 = '0;
`endif

  // Round-robin grant: on a tie, the requester that did not win last time is granted
  always_comb begin
    elig0 = req0_valid && !stall && !flush && !hold0;
    elig1 = req1_valid && !stall && !flush && !hold1;
    gnt0  = elig0 && (!elig1 || last_grant_q);
    gnt1  = elig1 && (!elig0 || !last_grant_q);
    hs    = gnt0 || gnt1;
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;
  end

  // Operand mux and sign/zero extension, plus the tag for the new op
  always_comb begin
    sel_op  = gnt1 ? req1_op  : req0_op;
    sel_rs1 = gnt1 ? req1_rs1 : req0_rs1;
    sel_rs2 = gnt1 ? req1_rs2 : req0_rs2;
    sel_rd  = gnt1 ? req1_rd  : req0_rd;
    src_a_d = {((sel_op == OP_MULH) || (sel_op == OP_MULHSU)) && sel_rs1[31], sel_rs1};
    src_b_d = {(sel_op == OP_MULH) && sel_rs2[31], sel_rs2};
    new_tag.valid = hs;
    new_tag.id    = gnt1;
    new_tag.lower = (sel_op == OP_MUL);
    new_tag.rd    = sel_rd;
  end

  // Round-robin pointer; resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

  // Multiplier operand registers; the sources hold their value between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_valid_q <= 1'b0;
      src_a_q     <= '0;
      src_b_q     <= '0;
    end else begin
      mul_valid_q <= hs;
      if (hs) begin
        src_a_q <= src_a_d;
        src_b_q <= src_b_d;
      end
    end
  end

  // Tag shift register; stall does not freeze it, flush kills everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if (flush) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Route the exiting result to its requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_rd_q     <= '0;
      rsp1_rd_q     <= '0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
    end else if (flush) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      rsp0_valid_q <= exit_tag.valid && !exit_tag.id;
      rsp1_valid_q <= exit_tag.valid && exit_tag.id;
      if (exit_tag.valid && !exit_tag.id) begin
        rsp0_rd_q     <= exit_tag.rd;
        rsp0_result_q <= exit_word;
      end
      if (exit_tag.valid && exit_tag.id) begin
        rsp1_rd_q     <= exit_tag.rd;
        rsp1_result_q <= exit_word;
      end
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign mul_valid   = mul_valid_q;
  assign mul_src_a   = src_a_q;
  assign mul_src_b   = src_b_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_rd     = rsp0_rd_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_rd     = rsp1_rd_q;
  assign rsp1_result = rsp1_result_q;

endmodule
